// File: rtl/ov7670_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_cfg_sequencer
// Purpose  : Walks the OV7670 register-init ROM and issues one SCCB write
//            (DEV_ADDR, reg, data) per table entry to a byte-level SCCB write
//            master. ROM control words insert delays (16'hFFF0) or end the
//            table (16'hFFFF). Reports completion (done) or a sticky error.
// Ports    : clk, reset (sync, active-high), start (1-cycle pulse)
//            rom_addr / rom_dout : synchronous ROM, data 1 cycle after addr
//            wr_valid / wr_ready : write request handshake to SCCB master
//            wr_dev / wr_reg / wr_data : write payload
//            wr_done / wr_nack   : transaction result (nack qualified by done)
//            busy, done, error, wr_count : status
// Options  : define OV_CFG_RETRY_EN to retry NACKed writes up to MAX_RETRY
//            extra times; without it the first NACK fails the sequence.
// Revision : 1.0  initial release
// ============================================================================
module ov7670_cfg_sequencer #(
  parameter int          ADDR_W       = 8,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter int          DELAY_CYCLES = 250_000,
  parameter int          MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_dout,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [7:0]        wr_dev,
  output logic [7:0]        wr_reg,
  output logic [7:0]        wr_data,
  input  logic              wr_done,
  input  logic              wr_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] wr_count
);

  localparam logic [15:0]       c_end_marker   = 16'hFFFF;
  localparam logic [15:0]       c_delay_marker = 16'hFFF0;
  localparam logic [ADDR_W-1:0] c_last_addr    = '1;
  localparam int                c_dly_w        = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [c_dly_w-1:0] c_dly_last    = c_dly_w'(DELAY_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_ROMWAIT  = 4'd2,
    S_DECODE   = 4'd3,
    S_ISSUE    = 4'd4,
    S_WAITDONE = 4'd5,
    S_DELAY    = 4'd6,
    S_FINISH   = 4'd7,
    S_FAIL     = 4'd8
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [ADDR_W-1:0]   r_rom_addr,  w_rom_addr_nxt;
  logic [7:0]          r_wr_reg,    w_wr_reg_nxt;
  logic [7:0]          r_wr_data,   w_wr_data_nxt;
  logic [ADDR_W-1:0]   r_wr_count,  w_wr_count_nxt;
  logic [c_dly_w-1:0]  r_delay_cnt, w_delay_cnt_nxt;

`ifdef OV_CFG_RETRY_EN
  localparam int                   c_retry_w   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [c_retry_w-1:0] c_retry_max = c_retry_w'(MAX_RETRY);
  logic [c_retry_w-1:0] r_retry_cnt, w_retry_cnt_nxt;
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rom_addr  <= '0;
      r_wr_reg    <= '0;
      r_wr_data   <= '0;
      r_wr_count  <= '0;
      r_delay_cnt <= '0;
`ifdef OV_CFG_RETRY_EN
      r_retry_cnt <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_wr_reg    <= w_wr_reg_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_wr_count  <= w_wr_count_nxt;
      r_delay_cnt <= w_delay_cnt_nxt;
`ifdef OV_CFG_RETRY_EN
      r_retry_cnt <= w_retry_cnt_nxt;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_rom_addr_nxt  = r_rom_addr;
    w_wr_reg_nxt    = r_wr_reg;
    w_wr_data_nxt   = r_wr_data;
    w_wr_count_nxt  = r_wr_count;
    w_delay_cnt_nxt = r_delay_cnt;
`ifdef OV_CFG_RETRY_EN
    w_retry_cnt_nxt = r_retry_cnt;
`endif
    wr_valid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    error    = 1'b0;

    case (r_state)
      // Resting states; done/error stay visible until the next start.
      S_IDLE, S_FINISH, S_FAIL: begin
        busy  = 1'b0;
        done  = (r_state == S_FINISH);
        error = (r_state == S_FAIL);
        if (start) begin
          w_rom_addr_nxt = '0;
          w_wr_count_nxt = '0;
`ifdef OV_CFG_RETRY_EN
          w_retry_cnt_nxt = '0;
`endif
          w_state_nxt = S_FETCH;
        end
      end

      S_FETCH:   w_state_nxt = S_ROMWAIT;
      S_ROMWAIT: w_state_nxt = S_DECODE;

      S_DECODE: begin
        if (rom_dout == c_end_marker) begin
          w_state_nxt = S_FINISH;
        end else if (rom_dout == c_delay_marker) begin
          w_delay_cnt_nxt = '0;
          w_state_nxt     = S_DELAY;
        end else begin
          // Payload is latched here so it stays stable through any stall.
          w_wr_reg_nxt  = rom_dout[15:8];
          w_wr_data_nxt = rom_dout[7:0];
`ifdef OV_CFG_RETRY_EN
          w_retry_cnt_nxt = '0;
`endif
          w_state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wr_valid = 1'b1;
        if (wr_ready) begin
          w_state_nxt = S_WAITDONE;
        end
      end

      S_WAITDONE: begin
        if (wr_done) begin
          if (!wr_nack) begin
            w_wr_count_nxt = r_wr_count + ADDR_W'(1);
`ifdef OV_CFG_RETRY_EN
            w_retry_cnt_nxt = '0;
`endif
            // The last table slot finishes the run instead of wrapping to 0.
            if (r_rom_addr == c_last_addr) begin
              w_state_nxt = S_FINISH;
            end else begin
              w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
              w_state_nxt    = S_FETCH;
            end
          end else begin
`ifdef OV_CFG_RETRY_EN
            // Reissue from the latched payload; the ROM is not re-read.
            if (r_retry_cnt < c_retry_max) begin
              w_retry_cnt_nxt = r_retry_cnt + c_retry_w'(1);
              w_state_nxt     = S_ISSUE;
            end else begin
              w_state_nxt = S_FAIL;
            end
`else
            w_state_nxt = S_FAIL;
`endif
          end
        end
      end

      S_DELAY: begin
        if (r_delay_cnt == c_dly_last) begin
          if (r_rom_addr == c_last_addr) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
            w_state_nxt    = S_FETCH;
          end
        end else begin
          w_delay_cnt_nxt = r_delay_cnt + c_dly_w'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rom_addr = r_rom_addr;
  assign wr_dev   = DEV_ADDR;
  assign wr_reg   = r_wr_reg;
  assign wr_data  = r_wr_data;
  assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ov7670_cfg_sequencer
// Purpose  : Self-checking bench for ov7670_cfg_sequencer. A synchronous ROM
//            model and a behavioural SCCB master responder drive the DUT; a
//            table-walking reference model predicts the issued writes and the
//            final status. Honours OV_CFG_RETRY_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_ov7670_cfg_sequencer;

  localparam int ADDR_W  = 4;
  localparam int DLY     = 10;
  localparam int MAXR_P  = 3;
  localparam int TIMEOUT = 3000;
`ifdef OV_CFG_RETRY_EN
  localparam int MODEL_RETRY = MAXR_P;
`else
  localparam int MODEL_RETRY = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_dout = '0;
  logic              wr_valid;
  logic              wr_ready = 1'b0;
  logic [7:0]        wr_dev, wr_reg, wr_data;
  logic              wr_done = 1'b0;
  logic              wr_nack = 1'b0;
  logic              busy, done, error;
  logic [ADDR_W-1:0] wr_count;

  ov7670_cfg_sequencer #(
    .ADDR_W(ADDR_W), .DEV_ADDR(8'h42), .DELAY_CYCLES(DLY), .MAX_RETRY(MAXR_P)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_dout(rom_dout),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_dev(wr_dev), .wr_reg(wr_reg), .wr_data(wr_data),
    .wr_done(wr_done), .wr_nack(wr_nack),
    .busy(busy), .done(done), .error(error), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for an address appears one clock later.
  logic [15:0] rom [16];
  always @(posedge clk) rom_dout <= rom[rom_addr];

  // Reset as seen by the DUT at the last edge; lets the responder follow it.
  logic rst_seen = 1'b1;
  always @(posedge clk) rst_seen <= reset;

  // Responder controls and logs
  bit          nack_plan [64];
  int          resp_idx = 0;
  bit          rand_timing = 0;
  int          stall_max = 0, lat_max = 0, fixed_stall = 0, fixed_lat = 0;
  bit          spurious_en = 0;
  logic [15:0] got_q [$];
  int          accepts = 0, valid_cycles = 0, stab_err = 0, dev_err = 0;

  // Reference model results
  logic [15:0] exp_q [$];
  bit          exp_done, exp_error;
  int          exp_count;
  logic [ADDR_W-1:0] exp_fail_addr;

  int n_checks = 0;
  int n_pass   = 0;

  // --------------------------------------------------------------------------
  // Behavioural SCCB write master: random/fixed accept stall, random/fixed
  // completion latency, NACK per accepted transaction from nack_plan.
  // --------------------------------------------------------------------------
  initial begin : responder
    bit          pending;
    bit          m_nack;
    bit          last_valid;
    int          lat, stall_left;
    logic [7:0]  last_reg, last_data, last_dev, hold_reg, hold_data;
    pending = 0; m_nack = 0; last_valid = 0; lat = 0; stall_left = 0;
    last_reg = '0; last_data = '0; last_dev = '0; hold_reg = '0; hold_data = '0;
    forever begin
      @(negedge clk);
      wr_done = 1'b0;
      wr_nack = 1'b0;
      if (rst_seen) begin
        pending = 0; wr_ready = 1'b0; last_valid = 0;
        continue;
      end
      if (wr_ready && last_valid) begin
        got_q.push_back({last_reg, last_data});
        accepts++;
        if (last_dev !== 8'h42) dev_err++;
        m_nack = (resp_idx < 64) ? nack_plan[resp_idx] : 1'b0;
        resp_idx++;
        lat = rand_timing ? $urandom_range(lat_max, 0) : fixed_lat;
        pending = 1;
        wr_ready = 1'b0;
      end
      if (pending) begin
        if (lat == 0) begin
          wr_done = 1'b1; wr_nack = m_nack; pending = 0;
        end else begin
          lat--;
        end
      end else if (wr_valid) begin
        valid_cycles++;
        if (!last_valid) begin
          stall_left = rand_timing ? $urandom_range(stall_max, 0) : fixed_stall;
          hold_reg = wr_reg; hold_data = wr_data;
        end else if (wr_reg !== hold_reg || wr_data !== hold_data) begin
          stab_err++;
        end
        if (stall_left > 0) begin
          stall_left--; wr_ready = 1'b0;
        end else begin
          wr_ready = 1'b1;
        end
      end else begin
        wr_ready = 1'b0;
        // Stray completion pulses while no transaction is outstanding.
        if (spurious_en && busy && $urandom_range(3, 0) == 0) begin
          wr_done = 1'b1; wr_nack = 1'b1;
        end
      end
      last_valid = wr_valid; last_reg = wr_reg; last_data = wr_data; last_dev = wr_dev;
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: walk the table by its rules.
  // --------------------------------------------------------------------------
  task automatic model_run();
    int addr, idx, r;
    bit ok, nk;
    logic [15:0] e;
    exp_q.delete(); exp_done = 0; exp_error = 0; exp_count = 0; exp_fail_addr = '0;
    addr = 0; idx = 0;
    forever begin
      e = rom[addr];
      if (e == 16'hFFFF) begin exp_done = 1; break; end
      if (e != 16'hFFF0) begin
        r = 0; ok = 0;
        forever begin
          exp_q.push_back(e);
          nk = (idx < 64) ? nack_plan[idx] : 1'b0;
          idx++;
          if (!nk) begin ok = 1; break; end
          if (r < MODEL_RETRY) r++; else break;
        end
        if (!ok) begin exp_error = 1; exp_fail_addr = ADDR_W'(addr); break; end
        exp_count++;
      end
      if (addr == 15) begin exp_done = 1; break; end
      addr++;
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers (no checking)
  // --------------------------------------------------------------------------
  task automatic fill_rom_end();
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    for (int i = 0; i < 64; i++) nack_plan[i] = 1'b0;
  endtask

  task automatic clear_logs();
    got_q.delete(); resp_idx = 0; accepts = 0; valid_cycles = 0; stab_err = 0; dev_err = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(output bit timed_out);
    int n;
    n = 0;
    while (!(done || error) && n < TIMEOUT) begin @(negedge clk); n++; end
    timed_out = (n >= TIMEOUT);
    @(negedge clk);
  endtask

  task automatic set_timing(bit rnd, int st, int lt);
    rand_timing = rnd; fixed_stall = st; fixed_lat = lt; stall_max = st; lat_max = lt;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (rom_addr !== 4'd0) $display("FAIL reset_rom_addr got %h exp 0", rom_addr); else n_pass++;
    n_checks++; if (wr_valid !== 1'b0) $display("FAIL reset_wr_valid got %b exp 0", wr_valid); else n_pass++;
    n_checks++; if (wr_dev !== 8'h42) $display("FAIL reset_wr_dev got %h exp 42", wr_dev); else n_pass++;
    n_checks++; if ({wr_reg, wr_data} !== 16'h0) $display("FAIL reset_payload got %h exp 0", {wr_reg, wr_data}); else n_pass++;
    n_checks++; if ({busy, done, error} !== 3'b000) $display("FAIL reset_status got %b exp 000", {busy, done, error}); else n_pass++;
    n_checks++; if (wr_count !== 4'd0) $display("FAIL reset_wr_count got %0d exp 0", wr_count); else n_pass++;
  endtask

  task automatic test_basic();
    bit to;
    fill_rom_end(); rom[0] = 16'h1280; rom[1] = 16'h1204;
    set_timing(0, 0, 0); spurious_en = 0; clear_logs();
    pulse_start(); wait_end(to);
    n_checks++; if (to) $display("FAIL basic_timeout got busy=%b exp done", busy); else n_pass++;
    n_checks++; if (got_q.size() != 2) $display("FAIL basic_nwrites got %0d exp 2", got_q.size()); else n_pass++;
    if (got_q.size() == 2) begin
      n_checks++; if (got_q[0] !== 16'h1280) $display("FAIL basic_write0 got %h exp 1280", got_q[0]); else n_pass++;
      n_checks++; if (got_q[1] !== 16'h1204) $display("FAIL basic_write1 got %h exp 1204", got_q[1]); else n_pass++;
    end
    n_checks++; if ({busy, done, error} !== 3'b010) $display("FAIL basic_status got %b exp 010", {busy, done, error}); else n_pass++;
    n_checks++; if (wr_count !== 4'd2) $display("FAIL basic_wr_count got %0d exp 2", wr_count); else n_pass++;
    n_checks++; if (dev_err != 0) $display("FAIL basic_wr_dev got %0d bad exp 0", dev_err); else n_pass++;
  endtask

  task automatic test_delay();
    bit to;
    int k;
    fill_rom_end(); rom[0] = 16'hFFF0; rom[1] = 16'h1100;
    set_timing(0, 0, 0); spurious_en = 1; clear_logs();
    pulse_start();
    // Now in the first cycle after the start edge. Expected first wr_valid:
    // fetch/wait/decode of the delay entry, DLY delay cycles, then
    // fetch/wait/decode of the write entry.
    k = 0;
    while (!wr_valid && k < 200) begin @(negedge clk); k++; end
    n_checks++; if (k != 3 + DLY + 3) $display("FAIL delay_latency got %0d exp %0d", k, 3 + DLY + 3); else n_pass++;
    wait_end(to);
    spurious_en = 0;
    n_checks++; if (to) $display("FAIL delay_timeout got busy=%b exp done", busy); else n_pass++;
    n_checks++; if (got_q.size() != 1 || got_q[0] !== 16'h1100) $display("FAIL delay_write got n=%0d exp 1 write 1100", got_q.size()); else n_pass++;
    n_checks++; if ({done, error} !== 2'b10 || wr_count !== 4'd1) $display("FAIL delay_status got %b cnt %0d exp 10 cnt 1", {done, error}, wr_count); else n_pass++;
  endtask

  task automatic test_stall();
    bit to;
    fill_rom_end(); rom[0] = 16'h1280;
    set_timing(0, 5, 1); spurious_en = 0; clear_logs();
    pulse_start(); wait_end(to);
    n_checks++; if (to) $display("FAIL stall_timeout got busy=%b exp done", busy); else n_pass++;
    n_checks++; if (valid_cycles != 6) $display("FAIL stall_valid_cycles got %0d exp 6", valid_cycles); else n_pass++;
    n_checks++; if (stab_err != 0) $display("FAIL stall_stability got %0d changes exp 0", stab_err); else n_pass++;
    n_checks++; if (accepts != 1) $display("FAIL stall_accepts got %0d exp 1", accepts); else n_pass++;
    n_checks++; if (done !== 1'b1 || wr_count !== 4'd1) $display("FAIL stall_done got %b cnt %0d exp 1 cnt 1", done, wr_count); else n_pass++;
  endtask

  task automatic test_retry();
    bit to;
    string tag;
    for (int s = 0; s < 3; s++) begin
      fill_rom_end(); rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'h1306;
      case (s)
        0: for (int i = 2; i < 5; i++) nack_plan[i] = 1'b1;  // entry 2: 3 NACKs then ACK
        1: for (int i = 2; i < 6; i++) nack_plan[i] = 1'b1;  // entry 2: 4 NACKs
        default: nack_plan[0] = 1'b1;                         // entry 0: single NACK
      endcase
      set_timing(0, 1, 2); spurious_en = 0; clear_logs(); model_run();
      tag = $sformatf("retry%0d", s);
      pulse_start(); wait_end(to);
      n_checks++; if (to) $display("FAIL %s_timeout got busy=%b exp end", tag, busy); else n_pass++;
      n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL %s_nissues got %0d exp %0d", tag, got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL %s_issue%0d got %h exp %h", tag, i, got_q[i], exp_q[i]); else n_pass++;
      end
      n_checks++; if ({busy, done, error} !== {1'b0, exp_done, exp_error}) $display("FAIL %s_status got %b exp 0%b%b", tag, {busy, done, error}, exp_done, exp_error); else n_pass++;
      n_checks++; if (wr_count !== ADDR_W'(exp_count)) $display("FAIL %s_wr_count got %0d exp %0d", tag, wr_count, exp_count); else n_pass++;
      if (exp_error) begin
        n_checks++; if (rom_addr !== exp_fail_addr) $display("FAIL %s_fail_addr got %0d exp %0d", tag, rom_addr, exp_fail_addr); else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    bit to;
    fill_rom_end();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0100 + 16'(i);
    rom[5] = 16'hFFF0;
    set_timing(0, 0, 0); spurious_en = 0; clear_logs();
    pulse_start(); wait_end(to);
    n_checks++; if (to) $display("FAIL wrap_timeout got busy=%b exp done", busy); else n_pass++;
    n_checks++; if (got_q.size() != 15) $display("FAIL wrap_nwrites got %0d exp 15", got_q.size()); else n_pass++;
    n_checks++; if (got_q.size() == 15 && got_q[14] !== 16'h010F) $display("FAIL wrap_last_write got %h exp 010f", got_q[14]); else n_pass++;
    n_checks++; if ({done, error} !== 2'b10 || wr_count !== 4'd15) $display("FAIL wrap_status got %b cnt %0d exp 10 cnt 15", {done, error}, wr_count); else n_pass++;
    n_checks++; if (rom_addr !== 4'd15) $display("FAIL wrap_rom_addr got %0d exp 15", rom_addr); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    bit to;
    int n;
    fill_rom_end(); rom[0] = 16'h1280; rom[1] = 16'h1204;
    set_timing(0, 0, 8); spurious_en = 0; clear_logs();
    pulse_start();
    n = 0;
    while (accepts < 2 && n < 200) begin @(negedge clk); n++; end
    n_checks++; if (n >= 200) $display("FAIL midrun_reach_waitdone got accepts=%0d exp 2", accepts); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (wr_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midrun_outputs got valid=%b busy=%b exp 0 0", wr_valid, busy); else n_pass++;
    n_checks++; if (rom_addr !== 4'd0 || wr_count !== 4'd0) $display("FAIL midrun_addr_count got %0d/%0d exp 0/0", rom_addr, wr_count); else n_pass++;
    set_timing(0, 0, 0); clear_logs();
    pulse_start(); wait_end(to);
    n_checks++; if (to || got_q.size() != 2 || got_q[0] !== 16'h1280) $display("FAIL midrun_rerun got to=%b n=%0d exp 2 writes from 1280", to, got_q.size()); else n_pass++;
    n_checks++; if (done !== 1'b1 || wr_count !== 4'd2) $display("FAIL midrun_rerun_status got %b cnt %0d exp 1 cnt 2", done, wr_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit to;
    fill_rom_end(); rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'h1306;
    set_timing(0, 0, 2); spurious_en = 0; clear_logs();
    pulse_start();
    repeat (6) @(negedge clk);
    start = 1'b1;                      // ignored: sequence already busy
    @(negedge clk); start = 1'b0;
    wait_end(to);
    n_checks++; if (to || got_q.size() != 3) $display("FAIL b2b_ignored_start got to=%b n=%0d exp 3", to, got_q.size()); else n_pass++;
    n_checks++; if (wr_count !== 4'd3 || done !== 1'b1) $display("FAIL b2b_first got cnt %0d done %b exp 3 1", wr_count, done); else n_pass++;
    clear_logs();
    pulse_start();
    n_checks++; if ({busy, done, wr_count} !== {2'b10, 4'd0}) $display("FAIL b2b_restart_clear got %b exp 100000", {busy, done, wr_count}); else n_pass++;
    wait_end(to);
    n_checks++; if (to || got_q.size() != 3 || got_q[2] !== 16'h1306) $display("FAIL b2b_second got to=%b n=%0d exp 3 ending 1306", to, got_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    bit to;
    string tag;
    logic [15:0] v;
    for (int it = 0; it < 20; it++) begin
      fill_rom_end();
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(9, 0))
          0: rom[i] = 16'hFFF0;
          1: rom[i] = 16'hFFFF;
          default: begin
            v[15:8] = 8'($urandom_range(254, 0));
            v[7:0]  = 8'($urandom_range(255, 0));
            rom[i]  = v;
          end
        endcase
      end
      for (int i = 0; i < 64; i++) nack_plan[i] = ($urandom_range(4, 0) == 0);
      set_timing(1, 3, 4); spurious_en = 1'($urandom_range(1, 0)); clear_logs(); model_run();
      tag = $sformatf("rand%0d", it);
      pulse_start(); wait_end(to);
      n_checks++; if (to) $display("FAIL %s_timeout got busy=%b exp end", tag, busy); else n_pass++;
      n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL %s_nissues got %0d exp %0d", tag, got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL %s_issue%0d got %h exp %h", tag, i, got_q[i], exp_q[i]); else n_pass++;
      end
      n_checks++; if ({busy, done, error} !== {1'b0, exp_done, exp_error}) $display("FAIL %s_status got %b exp 0%b%b", tag, {busy, done, error}, exp_done, exp_error); else n_pass++;
      n_checks++; if (wr_count !== ADDR_W'(exp_count)) $display("FAIL %s_wr_count got %0d exp %0d", tag, wr_count, exp_count); else n_pass++;
      n_checks++; if (stab_err != 0 || dev_err != 0) $display("FAIL %s_payload got %0d/%0d bad exp 0/0", tag, stab_err, dev_err); else n_pass++;
      if (exp_error) begin
        n_checks++; if (rom_addr !== exp_fail_addr) $display("FAIL %s_fail_addr got %0d exp %0d", tag, rom_addr, exp_fail_addr); else n_pass++;
      end
    end
    spurious_en = 0;
  endtask

  initial begin
    fill_rom_end();
    test_reset();
    test_basic();
    test_delay();
    test_stall();
    test_retry();
    test_wrap();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
